or1k_branch_predictor_gshare: RTL and testbench
===============================================

Name: or1k_branch_predictor_gshare

Overview:
Parametrised dynamic conditional-branch predictor for the decode stage, replacing the static backward-taken/forward-not-taken rule. It holds a table of saturating counters indexed by PC XOR speculative global history. Entries that have never been trained fall back to the static rule. An in-order in-flight queue carries each prediction's index and history to the execute stage, which resolves it, trains the table and repairs history on a mispredict.

Parameters:
OPTION_OPERAND_WIDTH, 32, PC width.
INDEX_WIDTH, 6, log2 of counter-table depth (1..8).
HISTORY_WIDTH, 4, global history bits (0..INDEX_WIDTH; 0 = pure bimodal).
COUNTER_WIDTH, 2, saturating counter width (>=2).
INFLIGHT_DEPTH, 2, in-flight queue entries (power of 2, >=1).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
op_bf_i  in  1  decode instruction is l.bf
op_bnf_i  in  1  decode instruction is l.bnf
immjbr_upper_i  in  10  upper branch-offset bits; bit 9 = backward
brn_pc_i  in  OPTION_OPERAND_WIDTH  decode instruction PC
padv_decode_i  in  1  decode advances; commits the prediction
predicted_flag_o  out  1  predicted flag value for the decode branch
resolve_valid_i  in  1  oldest in-flight branch resolved in execute
resolve_taken_i  in  1  actual direction of that branch
mispredict_o  out  1  registered one-cycle pulse: resolved direction differed
full_o  out  1  in-flight queue full
empty_o  out  1  in-flight queue empty

Behaviour:
- Index: idx = brn_pc_i[INDEX_WIDTH+1:2] XOR zero-extended ghr (HISTORY_WIDTH LSBs).
- Table: 2^INDEX_WIDTH entries of {valid, counter}, in flops.
- predicted_taken = counter MSB when the entry is valid.
- predicted_taken = immjbr_upper_i[9] (static rule) when the entry is invalid.
- predicted_flag_o = op_bf_i ? predicted_taken : op_bnf_i ? !predicted_taken : 0. Purely combinational from inputs and current state.
- Push occurs on padv_decode_i & (op_bf_i | op_bnf_i) & !full_o:
  - enqueue {idx, predicted_taken, ghr};
  - ghr <= {ghr[HISTORY_WIDTH-2:0], predicted_taken} (speculative).
- Full queue: push dropped, ghr unchanged, prediction still driven. No update is ever issued for that branch.
- Resolve occurs on resolve_valid_i & !empty_o; it pops the head entry.
- Training on resolve:
  - Valid entry: counter +1 if taken, -1 if not, saturating at 0 and 2^COUNTER_WIDTH-1.
  - Invalid entry: set valid; counter = 2^(CW-1) if taken, 2^(CW-1)-1 if not (weak state).
- Resolve when empty: ignored; no state change, no pulse.
- Mispredict (resolve_taken_i != stored predicted_taken):
  - next cycle mispredict_o = 1 for exactly one cycle;
  - ghr <= {stored_ghr[HW-2:0], resolve_taken_i};
  - the whole queue is flushed (all younger entries are wrong-path).
- Correct resolve: ghr untouched; mispredict_o = 0.
- Simultaneous push and resolve:
  - no mispredict: both happen; occupancy unchanged; push works when full.
  - mispredict: flush and repair win; push discarded; no ghr shift from the push.
- Table write and read hit the same index in one cycle: prediction sees the pre-update value (no bypass).
- Queue pointers wrap modulo INFLIGHT_DEPTH; full/empty are derived from a count register.
- Reset (asynchronous, rst = 0): all valid bits 0, counters 0, ghr 0, queue empty, mispredict_o 0.
  - Outputs then: full_o 0, empty_o 1; predicted_flag_o follows the static rule.
  - Reset mid-operation discards in-flight entries; no pulse on release.
- HISTORY_WIDTH = 0: ghr absent; idx = PC bits only; repair is a no-op.

Test Plan:
- After reset, l.bf with immjbr_upper_i = 10'h200 (backward) gives predicted_flag_o = 1. The same with 10'h000 gives 0. Matching l.bnf gives 0 and 1.
- Bimodal config (HW = 0), PC 0x100, l.bf forward:
  - resolve not-taken -> entry valid, counter 1, prediction 0.
  - resolve taken -> counter 2, prediction 1.
  - three more taken -> counter stays 3.
- Defaults: push l.bf at 0x40 (predicts 0), resolve taken -> mispredict_o high exactly one cycle later. ghr = 4'b0001, queue empty.
- INFLIGHT_DEPTH = 2: two pushes -> full_o = 1. A third decode branch is not queued and ghr is unchanged. Resolving one -> full_o = 0.
- Queue full, push and correct resolve in the same cycle -> count stays 2, ghr shifted once. The same with a mispredicting resolve -> queue empty, ghr = repaired value.
- Assert rst mid-stream with two entries queued -> immediately empty_o = 1, mispredict_o = 0. A resolve after release is ignored.

Source files
------------

// File: rtl/or1k_branch_predictor_gshare.sv
// or1k_branch_predictor_gshare: gshare conditional-branch predictor with static fallback and in-flight repair queue
module or1k_branch_predictor_gshare #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int HISTORY_WIDTH = 4,
  parameter int COUNTER_WIDTH = 2,
  parameter int INFLIGHT_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic op_bf_i,
  input  logic op_bnf_i,
  input  logic [9:0] immjbr_upper_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
  input  logic padv_decode_i,
  output logic predicted_flag_o,
  input  logic resolve_valid_i,
  input  logic resolve_taken_i,
  output logic mispredict_o,
  output logic full_o,
  output logic empty_o
);
  localparam int N = 1 << INDEX_WIDTH;
  localparam int GW = HISTORY_WIDTH > 0 ? HISTORY_WIDTH : 1;
  localparam int PW = INFLIGHT_DEPTH > 1 ? $clog2(INFLIGHT_DEPTH) : 1;
  localparam int CNW = $clog2(INFLIGHT_DEPTH + 1);
  localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] WEAK_T = {1'b1, {(COUNTER_WIDTH-1){1'b0}}};
  localparam logic [COUNTER_WIDTH-1:0] WEAK_N = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic pred;
    logic [GW-1:0] ghr;
  } entry_t;
  logic valid [N];
  logic [COUNTER_WIDTH-1:0] cnt [N];
  logic [GW-1:0] ghr;
  entry_t q [INFLIGHT_DEPTH];
  entry_t head;
  logic [PW-1:0] wr, rd;
  logic [CNW-1:0] count;
  logic [INDEX_WIDTH-1:0] idx;
  logic [COUNTER_WIDTH-1:0] c, cnt_nxt;
  logic pred, pop, mis, push;
  // With no history configured the register is held at zero, so idx is pure PC
  function automatic logic [GW-1:0] shift(input logic [GW-1:0] g, input logic t);
    return HISTORY_WIDTH == 0 ? '0 : GW'({g, t});
  endfunction
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return INFLIGHT_DEPTH == 1 ? '0 : p + 1'b1;
  endfunction
  assign idx = brn_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
  assign pred = valid[idx] ? cnt[idx][COUNTER_WIDTH-1] : immjbr_upper_i[9];
  assign predicted_flag_o = op_bf_i ? pred : op_bnf_i ? !pred : 1'b0;
  assign full_o = count == CNW'(INFLIGHT_DEPTH);
  assign empty_o = count == '0;
  assign head = q[rd];
  assign pop = resolve_valid_i & !empty_o;
  assign mis = pop & (resolve_taken_i != head.pred);
  // A non-mispredicting pop frees a slot this cycle, so a full queue can still accept
  assign push = padv_decode_i & (op_bf_i | op_bnf_i) & (!full_o | pop) & !mis;
  assign c = cnt[head.idx];
  assign cnt_nxt = !valid[head.idx] ? (resolve_taken_i ? WEAK_T : WEAK_N) :
                   resolve_taken_i ? (c == CMAX ? c : c + 1'b1) : (c == '0 ? c : c - 1'b1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        valid[i] <= 1'b0;
        cnt[i] <= '0;
      end
      ghr <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      mispredict_o <= 1'b0;
    end else begin
      mispredict_o <= mis;
      if (pop) begin
        valid[head.idx] <= 1'b1;
        cnt[head.idx] <= cnt_nxt;
      end
      ghr <= mis ? shift(head.ghr, resolve_taken_i) : push ? shift(ghr, pred) : ghr;
      wr <= mis ? '0 : push ? nxt(wr) : wr;
      rd <= mis ? '0 : pop ? nxt(rd) : rd;
      count <= mis ? '0 : count + CNW'(push) - CNW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) q[wr] <= '{idx: idx, pred: pred, ghr: ghr};
endmodule

// File: tb/tb_or1k_branch_predictor_gshare.sv
// tb_or1k_branch_predictor_gshare: directed checks of the gshare predictor (default and bimodal configs)
module tb_or1k_branch_predictor_gshare;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic op_bf = 1'b0, op_bnf = 1'b0, padv = 1'b0, rv = 1'b0, rt = 1'b0;
  logic [9:0] imm = '0;
  logic [31:0] pc = '0;
  logic pf_d, mp_d, full_d, empty_d;
  logic pf_b, mp_b, full_b, empty_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  or1k_branch_predictor_gshare d (
    .clk(clk), .rst(rst), .op_bf_i(op_bf), .op_bnf_i(op_bnf), .immjbr_upper_i(imm),
    .brn_pc_i(pc), .padv_decode_i(padv), .predicted_flag_o(pf_d), .resolve_valid_i(rv),
    .resolve_taken_i(rt), .mispredict_o(mp_d), .full_o(full_d), .empty_o(empty_d)
  );
  or1k_branch_predictor_gshare #(.HISTORY_WIDTH(0)) b (
    .clk(clk), .rst(rst), .op_bf_i(op_bf), .op_bnf_i(op_bnf), .immjbr_upper_i(imm),
    .brn_pc_i(pc), .padv_decode_i(padv), .predicted_flag_o(pf_b), .resolve_valid_i(rv),
    .resolve_taken_i(rt), .mispredict_o(mp_b), .full_o(full_b), .empty_o(empty_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic train(input logic t);
    padv = 1'b1;
    step();
    padv = 1'b0;
    rv = 1'b1;
    rt = t;
    step();
    rv = 1'b0;
    #1;
  endtask
  initial begin
    #3;
    check("rst_empty", 32'(empty_d), 1);
    check("rst_full", 32'(full_d), 0);
    check("rst_mp", 32'(mp_d), 0);
    rst = 1'b1;
    op_bf = 1'b1; imm = 10'h200; #1;
    check("static_bf_back", 32'(pf_d), 1);
    imm = 10'h000; #1;
    check("static_bf_fwd", 32'(pf_d), 0);
    op_bf = 1'b0; op_bnf = 1'b1; imm = 10'h200; #1;
    check("static_bnf_back", 32'(pf_d), 0);
    imm = 10'h000; #1;
    check("static_bnf_fwd", 32'(pf_d), 1);
    op_bnf = 1'b0; op_bf = 1'b1; pc = 32'h100;
    step();
    train(1'b0);
    check("bim_valid", 32'(b.valid[0]), 1);
    check("bim_cnt1", 32'(b.cnt[0]), 1);
    check("bim_pred0", 32'(pf_b), 0);
    train(1'b1);
    check("bim_cnt2", 32'(b.cnt[0]), 2);
    check("bim_pred1", 32'(pf_b), 1);
    for (int i = 0; i < 3; i++) begin
      train(1'b1);
      check("bim_sat", 32'(b.cnt[0]), 3);
    end
    rst = 1'b0; #1; rst = 1'b1;
    step();
    pc = 32'h40; op_bf = 1'b1; imm = '0; #1;
    check("def_pred", 32'(pf_d), 0);
    padv = 1'b1;
    step();
    padv = 1'b0; rv = 1'b1; rt = 1'b1; #1;
    check("mp_before", 32'(mp_d), 0);
    step();
    rv = 1'b0;
    check("mp_pulse", 32'(mp_d), 1);
    check("mp_ghr", 32'(d.ghr), 32'b0001);
    check("mp_empty", 32'(empty_d), 1);
    check("mp_cnt", 32'(d.cnt[16]), 2);
    step();
    check("mp_one_cycle", 32'(mp_d), 0);
    padv = 1'b1;
    step();
    step();
    check("full_set", 32'(full_d), 1);
    check("full_ghr", 32'(d.ghr), 32'b0100);
    step();
    check("drop_ghr", 32'(d.ghr), 32'b0100);
    check("drop_full", 32'(full_d), 1);
    padv = 1'b0; rv = 1'b1; rt = 1'b0;
    step();
    rv = 1'b0;
    check("pop_full", 32'(full_d), 0);
    check("pop_ghr", 32'(d.ghr), 32'b0100);
    check("pop_mp", 32'(mp_d), 0);
    check("pop_cnt", 32'(d.cnt[17]), 1);
    padv = 1'b1;
    step();
    padv = 1'b0;
    check("refill_full", 32'(full_d), 1);
    check("refill_ghr", 32'(d.ghr), 32'b1000);
    padv = 1'b1; rv = 1'b1; rt = 1'b0;
    step();
    padv = 1'b0; rv = 1'b0; #1;
    check("sim_ok_full", 32'(full_d), 1);
    check("sim_ok_ghr", 32'(d.ghr), 32'b0000);
    check("sim_ok_mp", 32'(mp_d), 0);
    check("sim_pred", 32'(pf_d), 1);
    padv = 1'b1; rv = 1'b1; rt = 1'b1;
    step();
    padv = 1'b0; rv = 1'b0;
    check("sim_mis_empty", 32'(empty_d), 1);
    check("sim_mis_ghr", 32'(d.ghr), 32'b1001);
    check("sim_mis_mp", 32'(mp_d), 1);
    step();
    check("sim_mis_once", 32'(mp_d), 0);
    padv = 1'b1;
    step();
    step();
    padv = 1'b0;
    check("mid_full", 32'(full_d), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_empty", 32'(empty_d), 1);
    check("mid_full0", 32'(full_d), 0);
    check("mid_mp", 32'(mp_d), 0);
    check("mid_ghr", 32'(d.ghr), 0);
    rst = 1'b1; rv = 1'b1; rt = 1'b1;
    step();
    rv = 1'b0;
    check("post_empty", 32'(empty_d), 1);
    check("post_mp", 32'(mp_d), 0);
    check("post_valid", 32'(d.valid[16]), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
